// File: rtl/app_softreg_endpoint.sv
// ----------------------------------------------------------------------------
// app_softreg_endpoint
//
// App-side end of the virtualized SoftReg channel. It takes at most one
// request per cycle from the per-app demux and returns one response for every
// read. There is no backpressure, so reads never stall and are never dropped.
// The block also holds the start/run/done control FSM, the host-writable
// config registers and the app-driven status registers.
//
// Word index decode: idx = addr[ADDR_LSB +: IDX_BITS]
//   0                          CTRL   (W: bit0 start, bit1 clear; R: STATUS)
//   1                          STATUS (RO: [1:0] state, [63:32] run_cycles)
//   2 .. 2+NUM_CFG_REGS-1      CFG    (RW)
//   next NUM_STAT_REGS         STAT   (RO, sampled in the request cycle)
//   anything else              reads BAD_RD_VAL, writes ignored
//
// Ports
//   clk           clock
//   rst           synchronous, active-high reset
//   softreg_req   valid/is_write/addr/data from the SoftReg demux
//   softreg_resp  valid/data toward the app's response FIFO
//   cfg_regs      flattened config registers, reg k at [64k +: 64]
//   stat_regs     flattened status inputs, reg k at [64k +: 64]
//   app_start     one-cycle pulse on entry to RUN
//   app_busy      high while the FSM is in RUN
//   app_done      completion pulse or level, only looked at in RUN
//
// Build option
//   SOFTREG_EP_RESP_PIPE_EN  adds a second response register stage; read
//                            latency becomes 2 cycles, still one response per
//                            read and in order. Undefined: latency 1.
// ----------------------------------------------------------------------------

package app_softreg_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [63:0] data;
    } softreg_req_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
    } softreg_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ep_state_e;

endpackage

module app_softreg_endpoint
    import app_softreg_pkg::*;
#(
    parameter int          NUM_CFG_REGS  = 4,
    parameter int          NUM_STAT_REGS = 4,
    parameter int          ADDR_LSB      = 3,
    parameter int          IDX_BITS      = 8,
    parameter logic [63:0] CFG_RST_VAL   = 64'h0,
    parameter logic [63:0] BAD_RD_VAL    = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  softreg_req_t               softreg_req,
    output softreg_resp_t              softreg_resp,
    output logic [64*NUM_CFG_REGS-1:0] cfg_regs,
    input  logic [64*NUM_STAT_REGS-1:0] stat_regs,
    output logic                       app_start,
    output logic                       app_busy,
    input  logic                       app_done
);

    localparam int CFG_BASE  = 2;
    localparam int STAT_BASE = CFG_BASE + NUM_CFG_REGS;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [31:0] idx;
    logic        wr_en;
    logic        rd_en;
    logic        start_req;
    logic        clear_req;
    logic        unused_addr;

    assign idx       = 32'(softreg_req.addr[ADDR_LSB +: IDX_BITS]);
    assign wr_en     = softreg_req.valid &&  softreg_req.is_write;
    assign rd_en     = softreg_req.valid && !softreg_req.is_write;
    assign start_req = wr_en && (idx == 32'd0) && softreg_req.data[0];
    assign clear_req = wr_en && (idx == 32'd0) && softreg_req.data[1];
    // Byte-offset bits and bits above the decoded index do not take part in
    // the decode; addresses alias every 2^IDX_BITS words.
    assign unused_addr = ^softreg_req.addr;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ep_state_e     state_q, state_d;
    logic [31:0]   run_cycles_q, run_cycles_d;
    logic          app_start_q, app_start_d;
    logic [63:0]   cfg_q [NUM_CFG_REGS];
    logic [63:0]   cfg_d [NUM_CFG_REGS];
    softreg_resp_t resp_q, resp_d;
    softreg_resp_t resp_out;
    logic [63:0]   status_word;
    logic [63:0]   rd_data;

    assign status_word = {run_cycles_q, 30'd0, state_q};

    // FSM: state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of process ordering.
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state. Start wins over clear; start is ignored in RUN, and
    // app_done in RUN takes precedence over a concurrent start.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_req) state_d = ST_RUN;
            ST_RUN:  if (app_done)  state_d = ST_DONE;
            ST_DONE: begin
                if (start_req)      state_d = ST_RUN;
                else if (clear_req) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        app_busy    = (state_q == ST_RUN);
        app_start_d = (state_q != ST_RUN) && (state_d == ST_RUN);
    end

    assign app_start = app_start_q;

    // run_cycles counts every cycle spent in RUN, including the one in which
    // app_done is seen, and then holds until the next RUN entry.
    always_comb begin
        run_cycles_d = run_cycles_q;
        if (app_start_d)
            run_cycles_d = 32'd0;
        else if (state_q == ST_RUN && run_cycles_q != 32'hFFFF_FFFF)
            run_cycles_d = run_cycles_q + 32'd1;
    end

    // Config register writes
    always_comb begin
        cfg_d = cfg_q;
        for (int k = 0; k < NUM_CFG_REGS; k++) begin
            if (wr_en && idx == 32'(CFG_BASE + k)) cfg_d[k] = softreg_req.data;
        end
    end

    // Read mux: everything is sampled in the request cycle
    always_comb begin
        rd_data = BAD_RD_VAL;
        if (idx == 32'd0 || idx == 32'd1) rd_data = status_word;
        for (int k = 0; k < NUM_CFG_REGS; k++) begin
            if (idx == 32'(CFG_BASE + k)) rd_data = cfg_q[k];
        end
        for (int k = 0; k < NUM_STAT_REGS; k++) begin
            if (idx == 32'(STAT_BASE + k)) rd_data = stat_regs[64*k +: 64];
        end
    end

    always_comb begin
        resp_d.valid = rd_en;
        resp_d.data  = rd_en ? rd_data : 64'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cycles_q <= 32'd0;
            app_start_q  <= 1'b0;
            resp_q       <= '0;
            // NOTE: the config array is a handful of architectural registers
            // with a defined reset value, so it is reset like any other flop
            // rather than treated as uninitialised storage.
            for (int k = 0; k < NUM_CFG_REGS; k++) cfg_q[k] <= CFG_RST_VAL;
        end else begin
            run_cycles_q <= run_cycles_d;
            app_start_q  <= app_start_d;
            resp_q       <= resp_d;
            cfg_q        <= cfg_d;
        end
    end

`ifdef SOFTREG_EP_RESP_PIPE_EN
    softreg_resp_t resp_pipe_q, resp_pipe_d;

    assign resp_pipe_d = resp_q;

    always_ff @(posedge clk) begin
        if (rst) resp_pipe_q <= '0;
        else     resp_pipe_q <= resp_pipe_d;
    end

    assign resp_out = resp_pipe_q;
`else
    assign resp_out = resp_q;
`endif

    // A response already sitting in the output stage when rst rises must not
    // escape during the reset cycle, so the output is masked by rst directly.
    always_comb begin
        softreg_resp = '0;
        if (!rst) softreg_resp = resp_out;
    end

    for (genvar g = 0; g < NUM_CFG_REGS; g++) begin : g_cfg_out
        assign cfg_regs[64*g +: 64] = cfg_q[g];
    end

endmodule
